// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and helpers for pipeline-register blocks.
package pipe_reg_chain_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 4;

  // Bits needed to encode values 0..n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned w = 1; w < n; w = w * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One {valid, data} pipeline stage with synchronous reset, flush and load enable.
module pipe_reg_chain_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= src_valid;
      end
      // Data is only meaningful under valid, so it may load even while flushing.
      if (load) begin
        data_q <= src_data;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush and occupancy count.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] adv;

  // Unrolled adv chain: a stage advances if the sink is ready or any stage
  // at or downstream of it is empty. Avoids a self-referencing vector.
  always_comb begin
    adv = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      adv[i] = out_ready;
      for (int j = i; j < int'(DEPTH); j++) begin
        if (!stage_valid[j]) begin
          adv[i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_link
      assign src_valid = stage_valid[i-1];
      assign src_data  = stage_data[i-1];
    end

    pipe_reg_chain_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .load     (adv[i]),
      .src_valid(src_valid),
      .src_data (src_data),
      .valid    (stage_valid[i]),
      .data     (stage_data[i])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  logic          accept;
  logic          consume;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(accept) - CW'(consume);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
